// File: rtl/rr_merge_pkg.sv
// Shared definitions for the round-robin request merger: bus field widths,
// FSM state encoding and the response data returned on a timeout abort.
package rr_merge_pkg;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int BUS_RESP_W = DATA_W + 1;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Request word layout: {valid, addr, wdata, wstrb}, valid at the MSB.
  function automatic int bus_req_w(input int addr_w);
    return 1 + addr_w + DATA_W + STRB_W;
  endfunction

endpackage

// File: rtl/rr_merge_arb.sv
// Rotating-priority selector: returns the first asserted valid bit found
// scanning from i_ptr upward, wrapping modulo N_MASTERS. Purely combinational.
module rr_arb #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] i_vld,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic                 o_any,
  output logic [IDX_W-1:0]     o_idx
);

  int w_pos;

  // Scan from lowest priority to highest so the last hit (closest to i_ptr) wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_pos = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N_MASTERS;
      if (i_vld[w_pos]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/rr_merge.sv
// N-to-1 bus request merger with round-robin arbitration. One transfer is in
// flight at a time; an IDLE cycle separates transfers so a master holding
// valid after its ready is never re-granted on a stale request.
// Optional feature: define MERGE_TIMEOUT_EN to abort transfers that see no
// ready for TIMEOUT_CYCLES busy cycles (granted master gets 32'hDEADBEEF).
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTERS*bus_req_w(ADDR_W)-1:0] m_req,
  output logic [N_MASTERS*BUS_RESP_W-1:0]      m_resp,
  output logic [bus_req_w(ADDR_W)-1:0]         s_req,
  input  logic [BUS_RESP_W-1:0]                s_resp
);

  localparam int REQ_W = bus_req_w(ADDR_W);
  localparam int GW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("rr_merge: N_MASTERS and TIMEOUT_CYCLES must both be at least 2");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_gnt;
  logic [GW-1:0]       r_ptr;
  logic [GW-1:0]       w_ptr_nxt;
  logic [N_MASTERS-1:0] w_vld;
  logic                w_any;
  logic [GW-1:0]       w_idx;
  logic [REQ_W-1:0]    w_gnt_req;
  logic                w_ready;
  logic                w_tmo;
  logic                w_done;

  // Gather the valid bit of every master slice for the arbiter.
  always_comb begin
    w_vld = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_vld[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  rr_arb #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (GW)
  ) u_arb (
    .i_vld (w_vld),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_gnt_req = m_req[int'(r_gnt)*REQ_W +: REQ_W];
  assign w_ready   = s_resp[0];
  assign w_done    = (r_state == ST_BUSY) && (w_ready || w_tmo);
  assign w_ptr_nxt = (int'(r_gnt) == N_MASTERS - 1) ? '0 : r_gnt + GW'(1);

`ifdef MERGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Abort fires in the busy cycle where the counter has reached its last value.
  assign w_tmo = (r_state == ST_BUSY) && !w_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count busy cycles without ready; held at zero while idle so each grant starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE || w_ready || w_tmo) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: grant on any valid request, release on ready or abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner on grant; rotate priority past it when the transfer ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) r_gnt <= w_idx;
      if (w_done) r_ptr <= w_ptr_nxt;
    end
  end

  // Output routing: only the granted master is connected, and only while busy.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (r_state == ST_BUSY) begin
      s_req = w_gnt_req;
      if (w_tmo) begin
        s_req[REQ_W-1] = 1'b0;
        m_resp[int'(r_gnt)*BUS_RESP_W +: BUS_RESP_W] = {TIMEOUT_RDATA, 1'b1};
      end else begin
        m_resp[int'(r_gnt)*BUS_RESP_W +: BUS_RESP_W] = s_resp;
      end
    end
  end

endmodule
